// File: rtl/chacha_mem_pkg.sv
// Shared types and defaults for the ChaCha20 data-memory fetch block.
package chacha_mem_pkg;

  localparam int unsigned ADDR_W_DEF     = 14;
  localparam int unsigned MAX_WORDS_DEF  = 16;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/chacha_word_packer.sv
// Packs captured read bytes into 32-bit words and holds them in a valid/ready output register.
// CHACHA_FETCH_BSWAP_EN selects big-endian lane placement; default is little-endian.
module chacha_word_packer
  import chacha_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        accept,
  input  logic        last_byte,
  input  logic [7:0]  rd_data,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        word_last,
  output logic        issue_ok_c
);

  logic [1:0]  issue_lane;
  logic [1:0]  cap_lane;
  logic [1:0]  cap_pos_c;
  logic [1:0]  next_lane_c;
  logic        cap_valid;
  logic        cap_last;
  logic [31:0] sr;
  logic        sr_full;
  logic        sr_last;
  logic        out_free_c;

`ifdef CHACHA_FETCH_BSWAP_EN
  assign cap_pos_c = 2'd3 - cap_lane;
`else
  assign cap_pos_c = cap_lane;
`endif

  // Byte 3 may only be requested if its word is guaranteed a free output slot on arrival.
  assign next_lane_c = accept ? issue_lane + 2'd1 : issue_lane;
  assign out_free_c  = !sr_full && !(cap_valid && (cap_lane == 2'd3)) &&
                       (!word_valid || word_ready);
  assign issue_ok_c  = (next_lane_c != 2'd3) || out_free_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_lane <= 2'd0;
      cap_lane   <= 2'd0;
      cap_valid  <= 1'b0;
      cap_last   <= 1'b0;
      sr         <= 32'd0;
      sr_full    <= 1'b0;
      sr_last    <= 1'b0;
      word_data  <= 32'd0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      if (clear) begin
        issue_lane <= 2'd0;
      end else if (accept) begin
        issue_lane <= issue_lane + 2'd1;
      end
      cap_valid <= accept;
      cap_lane  <= issue_lane;
      cap_last  <= accept && last_byte;
      if (cap_valid) begin
        sr[{cap_pos_c, 3'b000} +: 8] <= rd_data;
      end
      sr_full <= cap_valid && (cap_lane == 2'd3);
      sr_last <= cap_valid && cap_last;
      if (sr_full) begin
        word_data  <= sr;
        word_valid <= 1'b1;
        word_last  <= sr_last;
      end else if (word_ready) begin
        word_valid <= 1'b0;
        word_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chacha_mem_fetch.sv
// Avalon-MM byte read master feeding 32-bit words to the ChaCha20 core.
// Optional CHACHA_FETCH_BSWAP_EN (in chacha_word_packer) selects big-endian packing.
module chacha_mem_fetch
  import chacha_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [7:0]        avm_readdata,
  output logic [31:0]       word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS * BYTES_PER_WORD + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   bytes_left, bytes_left_next;
  logic [ADDR_W-1:0]  addr_next;
  logic               rd_next;
  logic               busy_next;
  logic               done_next;
  logic               zero_q, zero_next;
  logic               accept_c;
  logic               issue_ok_c;
  logic               last_hs_c;
  logic               launch_c;
  logic [4:0]         words_c;

  assign accept_c  = avm_read && !avm_waitrequest;
  assign words_c   = (num_words > 5'(MAX_WORDS)) ? 5'(MAX_WORDS) : num_words;
  assign last_hs_c = word_valid && word_ready && word_last;
  assign launch_c  = (state == IDLE) && start && (words_c != 5'd0);

  // Next-state, address counter and request generation.
  always_comb begin
    state_next      = state;
    bytes_left_next = bytes_left;
    addr_next       = avm_address;
    rd_next         = 1'b0;
    zero_next       = zero_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (words_c == 5'd0) begin
            state_next = FIN;
            zero_next  = 1'b1;
          end else begin
            state_next      = READ;
            addr_next       = base_addr;
            bytes_left_next = CNT_W'(words_c) * CNT_W'(BYTES_PER_WORD);
            rd_next         = 1'b1;
          end
        end
      end
      READ: begin
        if (accept_c) begin
          addr_next       = avm_address + ADDR_W'(1);
          bytes_left_next = bytes_left - CNT_W'(1);
        end
        if (avm_read && avm_waitrequest) begin
          rd_next = 1'b1;
        end else begin
          rd_next = (bytes_left_next != '0) && issue_ok_c;
        end
        if (bytes_left_next == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs_c) begin
          state_next = FIN;
        end
      end
      FIN: begin
        zero_next  = 1'b0;
        state_next = zero_q ? FIN : IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == FIN) && (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bytes_left     <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_chipselect <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      state          <= state_next;
      bytes_left     <= bytes_left_next;
      avm_address    <= addr_next;
      avm_read       <= rd_next;
      avm_chipselect <= rd_next;
      busy           <= busy_next;
      done           <= done_next;
      zero_q         <= zero_next;
    end
  end

  chacha_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (launch_c),
    .accept     (accept_c),
    .last_byte  (bytes_left == CNT_W'(1)),
    .rd_data    (avm_readdata),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_last  (word_last),
    .issue_ok_c (issue_ok_c)
  );

endmodule

// File: doc/chacha_mem_fetch.md
# chacha_mem_fetch

Avalon-MM read master that fetches a ChaCha20 input block (key, nonce, counter or plaintext) from the system's 8-bit on-chip data memory. It packs the bytes into 32-bit words and presents them on a valid/ready stream to the ChaCha20 core. It sits between the data-memory slave port and the core's word-load interface, and is started by the controller with a base byte address and a word count.

## Interface
- ADDR_W, 14, byte-address width of the data memory
- MAX_WORDS, 16, maximum words per transfer (one 64-byte block)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- base_addr  in  ADDR_W  byte address of the first byte
- num_words  in  5  words to fetch, 0..MAX_WORDS; values above MAX_WORDS are clamped to MAX_WORDS
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- avm_address  out  ADDR_W  byte address
- avm_chipselect  out  1  asserted together with avm_read
- avm_read  out  1  read request
- avm_waitrequest  in  1  fabric stall; the request is held while this is high
- avm_readdata  in  8  read data, fixed read latency of 1 cycle after acceptance
- word_data  out  32  packed word
- word_valid  out  1  word_data valid
- word_ready  in  1  consumer accepts the word
- word_last  out  1  marks the final word of the transfer

## Operation
- States and transitions:
  - IDLE: on start with num_words ≠ 0, latch base_addr and the word count, then go to READ. On start with num_words = 0, go to FIN.
  - READ: issue byte reads.
  - DRAIN: all reads have been issued; wait for the last word handshake.
  - FIN: assert done for 1 cycle, then return to IDLE.
- A read is accepted when avm_read is high and avm_waitrequest is low.
  - avm_address increments by 1 per accepted read and wraps modulo 2^ADDR_W.
  - While avm_waitrequest is high, avm_address, avm_read and avm_chipselect are held stable.
- Capture: avm_readdata is captured exactly 1 cycle after acceptance into byte lane (index mod 4) of the shift register.
- Packing is little-endian: byte at base+4k+i goes to word k, bits [8i+7:8i].
- Output register:
  - The completed word loads into word_data/word_valid the cycle after its 4th byte is captured.
  - It is held stable while word_valid=1 and word_ready=0.
- Backpressure: the read of byte 3 of a word is issued only if the output register is empty or is handshaking in the same cycle. Bytes 0–2 are issued freely. No data is ever lost or overwritten.
- word_last=1 only together with the final word.
- busy=1 in every state except IDLE.
- start while busy: ignored, with no effect on the current transfer.

## Timing
- Reset values: busy 0, done 0, avm_read 0, avm_chipselect 0, avm_address 0, word_valid 0, word_data 0, word_last 0, state IDLE.
- Unstalled throughput is 1 byte per cycle, i.e. 1 word per 4 cycles when word_ready is held high.
- Latency:
  - start → first avm_read: 1 cycle.
  - acceptance of byte 3 → word_valid: 2 cycles.
- done is asserted 1 cycle after the handshake of the word_last word.
- num_words = 0: done is asserted 2 cycles after start, with no reads and no words.
- Reset asserted mid-transfer: all outputs clear asynchronously and any in-flight read data is discarded. The next start after reset release behaves normally.

## Configuration
- CHACHA_FETCH_BSWAP_EN
  - Defined: big-endian packing; byte i of a word goes to bits [31-8i:24-8i].
  - Undefined: little-endian packing, as required by ChaCha20.

## Structure
- Shared package chacha_mem_pkg holds:
  - the state enum (IDLE, READ, DRAIN, FIN)
  - ADDR_W and MAX_WORDS defaults
  - BYTES_PER_WORD = 4
- Sub-module chacha_word_packer holds the byte lane counter, shift register, output register and the byte-3 issue gate. The top level holds the FSM, the address counter and the word counter.

## Test plan
- Single word, LE: memory at 0x0010..0x0013 = 01 02 03 04; start with base 0x0010, num_words 1 → word 0x04030201 with word_last=1; done 1 cycle after the handshake.
- Full block: base 0x0100, num_words 16, word_ready held 1 → 64 consecutive reads at 0x0100..0x013F with no gaps; 16 words, word_last only on the 16th.
- Backpressure: word_ready low for 10 cycles after the first word_valid → word_data stable; at most 3 reads issued for word 2; all 16 words correct and in order.
- Wrap: base 0x3FFE, num_words 1 → addresses 3FFE, 3FFF, 0000, 0001; word correct.
- Waitrequest: avm_waitrequest high for 3 cycles on byte 1 → address and read held stable; data correct; num_words=0 → done with no avm_read.
- Reset at byte 5 of a 4-word transfer → outputs 0 immediately; a new start fetches correct data.
